wav_tcm_arb: RTL and testbench
==============================

WAV_TCM_ARB -- requirements
Module: wav_tcm_arb

Interface
REQ-001 Parameter AWIDTH, default 32: address width of both requesters and the TCM port.
REQ-002 Parameter DWIDTH, default 32: data width; legal values are 32 and 64.
REQ-003 Parameter STRB_WIDTH, default DWIDTH/8: byte-strobe width.
REQ-004 Parameter STARVE_LIMIT, default 8: consecutive denied cycles of port 1 before it is force-granted; legal range 1..255.
REQ-005 Parameter WAKE_CYCLES, default 4: cycles from sleep release until the TCM may be accessed; legal range 1..15.
REQ-006 Port i_clk, in, 1: clock.
REQ-007 Port i_reset, in, 1: reset; asynchronous, active-high.
REQ-008 Ports i_p0_req / i_p1_req, in, 1 each: access request (port 0 = CPU, port 1 = DMA/debug).
REQ-009 Ports i_pN_addr [AWIDTH], i_pN_wr [1], i_pN_byte_wr [STRB_WIDTH], i_pN_wdata [DWIDTH], in: request payload, held stable while req=1 and gnt=0.
REQ-010 Ports o_p0_gnt / o_p1_gnt, out, 1 each: request accepted this cycle.
REQ-011 Ports o_p0_rvalid / o_p1_rvalid, out, 1 each; o_pN_rdata, out, DWIDTH: read return data.
REQ-012 Ports o_tcm_cs, o_tcm_addr, o_tcm_wr, o_tcm_byte_wr, o_tcm_wdata, o_tcm_sleep, out: TCM access port.
REQ-013 Port i_tcm_rdata, in, DWIDTH: TCM read data, valid the cycle after a read access.
REQ-014 Ports i_sleep_req, in, 1; o_sleep_ack, out, 1: low-power handshake.

Function
REQ-015 FSM states: RUN, DRAIN, SLEEP, WAKE.
REQ-016 In RUN, at most one grant per cycle; a grant drives o_tcm_cs=1 combinationally with the granted payload in the same cycle.
REQ-017 Priority: port 0 wins, unless starve_cnt==STARVE_LIMIT and i_p1_req=1, in which case port 1 wins.
REQ-018 starve_cnt increments when i_p1_req=1 and o_p1_gnt=0; it clears on o_p1_gnt or i_p1_req=0; it saturates at STARVE_LIMIT.
REQ-019 A read granted in cycle N produces o_pN_rvalid=1 in cycle N+1 on the granted port only, with o_pN_rdata=i_tcm_rdata.
REQ-020 A one-bit return tag plus a valid flag, registered at grant, route read data; writes produce no rvalid.
REQ-021 o_pN_rdata is zero whenever o_pN_rvalid=0.
REQ-022 Back-to-back grants are legal every cycle, including read-after-write to the same address and port switches.
REQ-023 When no grant is issued, o_tcm_cs=0 and all other TCM payload outputs are 0.
REQ-024 RUN->DRAIN on i_sleep_req=1; DRAIN issues no grants; DRAIN->SLEEP once no read return is outstanding (at most one cycle).
REQ-025 In SLEEP: o_tcm_sleep=1, o_sleep_ack=1, no grants, and starve_cnt held.
REQ-026 SLEEP->WAKE on i_sleep_req=0; in WAKE, o_tcm_sleep=0, o_sleep_ack=0, no grants, and a counter runs WAKE_CYCLES cycles, then WAKE->RUN.
REQ-027 i_sleep_req deasserted while in DRAIN: the FSM still completes DRAIN->SLEEP->WAKE; no abort.
REQ-028 Requests held during DRAIN/SLEEP/WAKE are granted normally on return to RUN.

Reset
REQ-029 On i_reset: FSM=RUN, starve_cnt=0, wake counter=0, return tag/valid=0.
REQ-030 During and immediately after reset: all gnt, rvalid, rdata, o_tcm_* and o_sleep_ack outputs are 0.
REQ-031 A reset that arrives mid-read discards the pending return; no rvalid follows reset release.

Structure
REQ-032 The state enum (RUN/DRAIN/SLEEP/WAKE) and the port-index constants are defined in the shared package wav_tcm_pkg.
REQ-033 A single sub-module, wav_tcm_arb_fsm, holds the sleep/wake FSM and the wake counter; the arbitration and return path stay in the top level.
REQ-034 The TCM port connects directly to the existing TCM wrapper, which is configured non-pipelined.

Verification
REQ-035 p0 and p1 both read continuously, STARVE_LIMIT=8: p1 granted exactly once every 9th cycle; p0 receives all other grants.
REQ-036 p0 writes 0xDEADBEEF to 0x40 (strobe 0xF) in cycle N; p1 reads 0x40 in cycle N+1: o_p1_rvalid=1 at N+2 with 0xDEADBEEF, and o_p0_rvalid stays 0.
REQ-037 p0 read grant, then i_sleep_req=1 on the next cycle: rvalid for the read is delivered, then o_sleep_ack=1; no o_tcm_cs while ack=1.
REQ-038 i_sleep_req released with p1_req held, WAKE_CYCLES=4: o_tcm_sleep falls, and the first o_p1_gnt occurs exactly 4 cycles later.
REQ-039 i_reset asserted in the cycle after a read grant: no rvalid at any time after release; all outputs 0 during reset.
REQ-040 Random two-port traffic checked against a scoreboard model: every read returns the last written byte-merged data to the issuing port only.

Source files
------------

// File: rtl/wav_tcm_pkg.sv
// Shared definitions for the TCM arbiter: sleep/wake state encoding and
// return-tag values that identify the requesting port.
package wav_tcm_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SLEEP = 2'd2,
    ST_WAKE  = 2'd3
  } tcm_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/wav_tcm_arb_fsm.sv
// Low-power sequencing for the TCM arbiter: drains the read return, holds the
// TCM asleep while requested, then waits WAKE_CYCLES before accesses resume.
module wav_tcm_arb_fsm
  import wav_tcm_pkg::*;
#(
  parameter int WAKE_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_sleep_req,
  input  logic       i_rd_pending,
  output tcm_state_t o_state,
  output logic       o_tcm_sleep,
  output logic       o_sleep_ack
);

  localparam logic [3:0] WAKE_LAST = 4'(WAKE_CYCLES - 1);

  tcm_state_t state, state_nxt;
  logic [3:0] wake_cnt, wake_cnt_nxt;

  always_comb begin
    state_nxt    = state;
    wake_cnt_nxt = wake_cnt;
    case (state)
      ST_RUN:   if (i_sleep_req) state_nxt = ST_DRAIN;
      // A late release of i_sleep_req does not abort the drain.
      ST_DRAIN: if (!i_rd_pending) state_nxt = ST_SLEEP;
      ST_SLEEP: begin
        if (!i_sleep_req) begin
          state_nxt    = ST_WAKE;
          wake_cnt_nxt = 4'd0;
        end
      end
      ST_WAKE: begin
        if (wake_cnt == WAKE_LAST) begin
          state_nxt    = ST_RUN;
          wake_cnt_nxt = 4'd0;
        end else begin
          wake_cnt_nxt = wake_cnt + 4'd1;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= ST_RUN;
      wake_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      wake_cnt <= wake_cnt_nxt;
    end
  end

  assign o_state     = state;
  assign o_tcm_sleep = (state == ST_SLEEP);
  assign o_sleep_ack = (state == ST_SLEEP);

endmodule

// File: rtl/wav_tcm_arb.sv
// Two-port arbiter in front of a non-pipelined TCM: CPU priority with a
// starvation escape for the DMA/debug port, tagged read return, sleep handshake.
module wav_tcm_arb
  import wav_tcm_pkg::*;
#(
  parameter int AWIDTH       = 32,
  parameter int DWIDTH       = 32,
  parameter int STRB_WIDTH   = DWIDTH / 8,
  parameter int STARVE_LIMIT = 8,
  parameter int WAKE_CYCLES  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_p0_req,
  input  logic [AWIDTH-1:0]     i_p0_addr,
  input  logic                  i_p0_wr,
  input  logic [STRB_WIDTH-1:0] i_p0_byte_wr,
  input  logic [DWIDTH-1:0]     i_p0_wdata,
  input  logic                  i_p1_req,
  input  logic [AWIDTH-1:0]     i_p1_addr,
  input  logic                  i_p1_wr,
  input  logic [STRB_WIDTH-1:0] i_p1_byte_wr,
  input  logic [DWIDTH-1:0]     i_p1_wdata,
  output logic                  o_p0_gnt,
  output logic                  o_p1_gnt,
  output logic                  o_p0_rvalid,
  output logic [DWIDTH-1:0]     o_p0_rdata,
  output logic                  o_p1_rvalid,
  output logic [DWIDTH-1:0]     o_p1_rdata,
  output logic                  o_tcm_cs,
  output logic [AWIDTH-1:0]     o_tcm_addr,
  output logic                  o_tcm_wr,
  output logic [STRB_WIDTH-1:0] o_tcm_byte_wr,
  output logic [DWIDTH-1:0]     o_tcm_wdata,
  output logic                  o_tcm_sleep,
  input  logic [DWIDTH-1:0]     i_tcm_rdata,
  input  logic                  i_sleep_req,
  output logic                  o_sleep_ack
);

  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
    return (v >= lim) ? lim : v + 8'd1;
  endfunction

  tcm_state_t state;
  logic [7:0] starve_cnt;
  logic       grant_en;
  logic       p1_win;
  logic       vld_p1;
  logic       tag_p1;

  wav_tcm_arb_fsm #(
    .WAKE_CYCLES (WAKE_CYCLES)
  ) u_fsm (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_sleep_req  (i_sleep_req),
    .i_rd_pending (vld_p1),
    .o_state      (state),
    .o_tcm_sleep  (o_tcm_sleep),
    .o_sleep_ack  (o_sleep_ack)
  );

  // Grants are combinational; i_reset also masks them so nothing leaks out during reset.
  assign grant_en = (state == ST_RUN) && !i_reset;
  assign p1_win   = i_p1_req && (!i_p0_req || (starve_cnt == STARVE_MAX));
  assign o_p1_gnt = grant_en && p1_win;
  assign o_p0_gnt = grant_en && i_p0_req && !p1_win;

  always_comb begin
    o_tcm_cs      = 1'b0;
    o_tcm_addr    = '0;
    o_tcm_wr      = 1'b0;
    o_tcm_byte_wr = '0;
    o_tcm_wdata   = '0;
    if (o_p1_gnt) begin
      o_tcm_cs      = 1'b1;
      o_tcm_addr    = i_p1_addr;
      o_tcm_wr      = i_p1_wr;
      o_tcm_byte_wr = i_p1_byte_wr;
      o_tcm_wdata   = i_p1_wdata;
    end else if (o_p0_gnt) begin
      o_tcm_cs      = 1'b1;
      o_tcm_addr    = i_p0_addr;
      o_tcm_wr      = i_p0_wr;
      o_tcm_byte_wr = i_p0_byte_wr;
      o_tcm_wdata   = i_p0_wdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      starve_cnt <= 8'd0;
    end else if (state != ST_SLEEP) begin
      if (!i_p1_req || o_p1_gnt) starve_cnt <= 8'd0;
      else                       starve_cnt <= sat_inc(starve_cnt, STARVE_MAX);
    end
  end

  // ---- stage p1: return tag registered at grant, data arrives from the TCM ----
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      vld_p1 <= 1'b0;
      tag_p1 <= PORT_CPU;
    end else begin
      vld_p1 <= o_tcm_cs && !o_tcm_wr;
      tag_p1 <= o_p1_gnt ? PORT_DMA : PORT_CPU;
    end
  end

  assign o_p0_rvalid = vld_p1 && (tag_p1 == PORT_CPU);
  assign o_p1_rvalid = vld_p1 && (tag_p1 == PORT_DMA);
  assign o_p0_rdata  = o_p0_rvalid ? i_tcm_rdata : '0;
  assign o_p1_rdata  = o_p1_rvalid ? i_tcm_rdata : '0;

endmodule

// File: tb/tb_wav_tcm_arb.sv
// Bench for wav_tcm_arb: TCM memory responder, directed sleep/starvation/reset
// scenarios and random two-port traffic checked against a word-level model.
module tb_wav_tcm_arb;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = 4;
  localparam int LIM  = 8;
  localparam int WAKE = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          p0_req, p0_wr, p1_req, p1_wr, sleep_req;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [SW-1:0] p0_strb, p1_strb;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          o_p0_gnt, o_p1_gnt, o_p0_rvalid, o_p1_rvalid;
  logic [DW-1:0] o_p0_rdata, o_p1_rdata;
  logic          o_tcm_cs, o_tcm_wr, o_tcm_sleep, o_sleep_ack;
  logic [AW-1:0] o_tcm_addr;
  logic [SW-1:0] o_tcm_byte_wr;
  logic [DW-1:0] o_tcm_wdata;
  logic [DW-1:0] tcm_rdata = '0;

  wav_tcm_arb #(
    .AWIDTH(AW), .DWIDTH(DW), .STRB_WIDTH(SW), .STARVE_LIMIT(LIM), .WAKE_CYCLES(WAKE)
  ) dut (
    .i_clk(clk), .i_reset(rst),
    .i_p0_req(p0_req), .i_p0_addr(p0_addr), .i_p0_wr(p0_wr), .i_p0_byte_wr(p0_strb), .i_p0_wdata(p0_wdata),
    .i_p1_req(p1_req), .i_p1_addr(p1_addr), .i_p1_wr(p1_wr), .i_p1_byte_wr(p1_strb), .i_p1_wdata(p1_wdata),
    .o_p0_gnt(o_p0_gnt), .o_p1_gnt(o_p1_gnt),
    .o_p0_rvalid(o_p0_rvalid), .o_p0_rdata(o_p0_rdata),
    .o_p1_rvalid(o_p1_rvalid), .o_p1_rdata(o_p1_rdata),
    .o_tcm_cs(o_tcm_cs), .o_tcm_addr(o_tcm_addr), .o_tcm_wr(o_tcm_wr),
    .o_tcm_byte_wr(o_tcm_byte_wr), .o_tcm_wdata(o_tcm_wdata), .o_tcm_sleep(o_tcm_sleep),
    .i_tcm_rdata(tcm_rdata), .i_sleep_req(sleep_req), .o_sleep_ack(o_sleep_ack)
  );

  function automatic int widx(input logic [AW-1:0] a);
    return int'((a >> 2) & 32'h3F);
  endfunction

  // Non-pipelined TCM: read data the cycle after access, garbage otherwise.
  logic [DW-1:0] tcm_mem [64];
  always @(posedge clk) begin
    if (o_tcm_cs && o_tcm_wr)
      for (int b = 0; b < SW; b++)
        if (o_tcm_byte_wr[b]) tcm_mem[widx(o_tcm_addr)][8*b +: 8] <= o_tcm_wdata[8*b +: 8];
    if (o_tcm_cs && !o_tcm_wr) tcm_rdata <= tcm_mem[widx(o_tcm_addr)];
    else                       tcm_rdata <= $urandom;
  end

  int checks = 0;
  int errors = 0;
  int m_starve = 0;
  bit m_pend = 0;
  bit m_pend_port = 0;
  logic [DW-1:0] m_pend_data = '0;
  logic [DW-1:0] ref_mem [64];
  bit last_g0 = 0, last_g1 = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_starve = 0; m_pend = 0; m_pend_port = 0; last_g0 = 0; last_g1 = 0;
  endtask

  // Check one cycle's outputs at the falling edge, then retire the cycle into the model.
  task automatic sample(input bit allow, input bit hold, input bit exp_slp);
    bit g0, g1, e_wr;
    logic [AW-1:0] e_addr;
    logic [SW-1:0] e_strb;
    logic [DW-1:0] e_wdata;
    int idx;
    @(negedge clk);
    g1 = allow && p1_req && (!p0_req || m_starve == LIM);
    g0 = allow && p0_req && !g1;
    e_wr = 0; e_addr = '0; e_strb = '0; e_wdata = '0;
    if (g1) begin
      e_wr = p1_wr; e_addr = p1_addr; e_strb = p1_strb; e_wdata = p1_wdata;
    end else if (g0) begin
      e_wr = p0_wr; e_addr = p0_addr; e_strb = p0_strb; e_wdata = p0_wdata;
    end
    chk("p0_gnt", 64'(o_p0_gnt), 64'(g0));
    chk("p1_gnt", 64'(o_p1_gnt), 64'(g1));
    chk("tcm_cs", 64'(o_tcm_cs), 64'(g0 | g1));
    chk("tcm_addr", 64'(o_tcm_addr), 64'(e_addr));
    chk("tcm_wr", 64'(o_tcm_wr), 64'(e_wr));
    chk("tcm_byte_wr", 64'(o_tcm_byte_wr), 64'(e_strb));
    chk("tcm_wdata", 64'(o_tcm_wdata), 64'(e_wdata));
    chk("p0_rvalid", 64'(o_p0_rvalid), 64'(m_pend && !m_pend_port));
    chk("p1_rvalid", 64'(o_p1_rvalid), 64'(m_pend && m_pend_port));
    chk("p0_rdata", 64'(o_p0_rdata), (m_pend && !m_pend_port) ? 64'(m_pend_data) : 64'd0);
    chk("p1_rdata", 64'(o_p1_rdata), (m_pend && m_pend_port) ? 64'(m_pend_data) : 64'd0);
    chk("tcm_sleep", 64'(o_tcm_sleep), 64'(exp_slp));
    chk("sleep_ack", 64'(o_sleep_ack), 64'(exp_slp));
    idx = widx(e_addr);
    if ((g0 || g1) && e_wr)
      for (int b = 0; b < SW; b++)
        if (e_strb[b]) ref_mem[idx][8*b +: 8] = e_wdata[8*b +: 8];
    m_pend      = (g0 || g1) && !e_wr;
    m_pend_port = g1;
    m_pend_data = ref_mem[idx];
    if (!hold) m_starve = (!p1_req || g1) ? 0 : ((m_starve < LIM) ? m_starve + 1 : LIM);
    last_g0 = g0;
    last_g1 = g1;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_p0_gnt", 64'(o_p0_gnt), 64'd0);
      chk("rst_p1_gnt", 64'(o_p1_gnt), 64'd0);
      chk("rst_p0_rvalid", 64'(o_p0_rvalid), 64'd0);
      chk("rst_p1_rvalid", 64'(o_p1_rvalid), 64'd0);
      chk("rst_p0_rdata", 64'(o_p0_rdata), 64'd0);
      chk("rst_p1_rdata", 64'(o_p1_rdata), 64'd0);
      chk("rst_tcm_cs", 64'(o_tcm_cs), 64'd0);
      chk("rst_tcm_addr", 64'(o_tcm_addr), 64'd0);
      chk("rst_tcm_wr", 64'(o_tcm_wr), 64'd0);
      chk("rst_tcm_byte_wr", 64'(o_tcm_byte_wr), 64'd0);
      chk("rst_tcm_wdata", 64'(o_tcm_wdata), 64'd0);
      chk("rst_tcm_sleep", 64'(o_tcm_sleep), 64'd0);
      chk("rst_sleep_ack", 64'(o_sleep_ack), 64'd0);
      advance();
    end
  endtask

  task automatic idle();
    p0_req = 0; p1_req = 0;
    sample(1, 0, 0);
    advance();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      tcm_mem[i] = '0;
      ref_mem[i] = '0;
    end
    sleep_req = 0;
    p0_req = 1; p0_wr = 1; p0_addr = 32'h40; p0_strb = 4'hF; p0_wdata = 32'h1234_5678;
    p1_req = 1; p1_wr = 0; p1_addr = 32'h44; p1_strb = 4'h3; p1_wdata = 32'h9ABC_DEF0;

    // Reset with requests asserted: everything must stay quiet.
    #2 rst = 1;
    model_reset();
    reset_cycles(2);
    rst = 0;
    idle();
    idle();

    // Write then read-after-write to the same address from the other port.
    p0_req = 1; p0_wr = 1; p0_addr = 32'h40; p0_strb = 4'hF; p0_wdata = 32'hDEAD_BEEF;
    sample(1, 0, 0);
    chk("raw_wr_gnt", 64'(o_p0_gnt), 64'd1);
    advance();
    p0_req = 0;
    p1_req = 1; p1_wr = 0; p1_addr = 32'h40;
    sample(1, 0, 0);
    chk("raw_rd_gnt", 64'(o_p1_gnt), 64'd1);
    advance();
    p1_req = 0;
    sample(1, 0, 0);
    chk("raw_p1_rvalid", 64'(o_p1_rvalid), 64'd1);
    chk("raw_p1_rdata", 64'(o_p1_rdata), 64'hDEAD_BEEF);
    chk("raw_p0_quiet", 64'(o_p0_rvalid), 64'd0);
    advance();
    idle();

    // Both ports read continuously: DMA gets exactly every ninth slot.
    p0_req = 1; p0_wr = 0; p0_addr = 32'h40;
    p1_req = 1; p1_wr = 0; p1_addr = 32'h44;
    for (int i = 0; i < 27; i++) begin
      sample(1, 0, 0);
      chk("starve_slot", 64'(o_p1_gnt), 64'((i % 9) == 8));
      advance();
    end
    idle();
    idle();

    // Read, then sleep request: return delivered before ack; no access while asleep.
    p0_req = 1; p0_wr = 0; p0_addr = 32'h40;
    sample(1, 0, 0);
    advance();
    p0_req = 0; sleep_req = 1;
    sample(1, 0, 0);
    chk("drain_rvalid", 64'(o_p0_rvalid), 64'd1);
    chk("drain_rdata", 64'(o_p0_rdata), 64'hDEAD_BEEF);
    advance();
    sample(0, 0, 0);
    advance();
    p1_req = 1; p1_wr = 0; p1_addr = 32'h40;
    for (int i = 0; i < 3; i++) begin
      sample(0, 1, 1);
      advance();
    end
    sleep_req = 0;
    sample(0, 1, 1);
    advance();
    for (int i = 0; i < WAKE; i++) begin
      sample(0, 0, 0);
      chk("wake_no_gnt", 64'(o_p1_gnt), 64'd0);
      advance();
    end
    sample(1, 0, 0);
    chk("wake_first_gnt", 64'(o_p1_gnt), 64'd1);
    advance();
    idle();
    idle();

    // Sleep request dropped during drain: sequence still runs to completion.
    sleep_req = 1;
    sample(1, 0, 0);
    advance();
    sleep_req = 0;
    p0_req = 1; p0_wr = 0; p0_addr = 32'h44;
    sample(0, 0, 0);
    advance();
    sample(0, 1, 1);
    chk("abort_ack", 64'(o_sleep_ack), 64'd1);
    advance();
    for (int i = 0; i < WAKE; i++) begin
      sample(0, 0, 0);
      advance();
    end
    sample(1, 0, 0);
    chk("held_req_gnt", 64'(o_p0_gnt), 64'd1);
    advance();
    idle();

    // Reset in the cycle after a read grant discards the return.
    p0_req = 1; p0_wr = 0; p0_addr = 32'h40;
    sample(1, 0, 0);
    advance();
    rst = 1; p1_req = 1;
    model_reset();
    reset_cycles(2);
    rst = 0;
    p0_req = 0; p1_req = 0;
    for (int i = 0; i < 3; i++) begin
      sample(1, 0, 0);
      chk("post_rst_rvalid", 64'(o_p0_rvalid), 64'd0);
      advance();
    end

    // Random two-port traffic; payload only changes once the port is granted or idle.
    for (int i = 0; i < 400; i++) begin
      if (!p0_req || last_g0) begin
        p0_req = ($urandom_range(0, 2) != 0);
        p0_wr = $urandom_range(0, 1);
        p0_addr = 32'h40 + 32'(4 * $urandom_range(0, 7));
        p0_strb = 4'($urandom_range(1, 15));
        p0_wdata = $urandom;
      end
      if (!p1_req || last_g1) begin
        p1_req = ($urandom_range(0, 2) != 0);
        p1_wr = $urandom_range(0, 1);
        p1_addr = 32'h40 + 32'(4 * $urandom_range(0, 7));
        p1_strb = 4'($urandom_range(1, 15));
        p1_wdata = $urandom;
      end
      sample(1, 0, 0);
      advance();
    end
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
